branch_control: RTL and testbench

BRANCH_CONTROL -- requirements
Module: branch_control

---
 rtl/branch_pkg.sv | 11 +
 rtl/branch_decoder.sv | 15 +
 rtl/branch_control.sv | 78 +++++++
 tb/tb_branch_control.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared opcode constants and FSM state type for the branch control slice.
package branch_pkg;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_JZ  = 2'b11;
    localparam logic [7:0] NOP    = 8'h00;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;
endpackage

// File: rtl/branch_decoder.sv
// Purely combinational decode of the instruction register into branch fields.
module branch_decoder
    import branch_pkg::*;
(
    input  logic [7:0] ir,
    output logic       is_branch,
    output logic       is_cond,
    output logic [7:0] disp
);
    always_comb begin
        is_branch = (ir[7:6] == OP_JMP) || (ir[7:6] == OP_JZ);
        is_cond   = (ir[7:6] == OP_JZ);
        disp      = {{2{ir[5]}}, ir[5:0]};
    end
endmodule

// File: rtl/branch_control.sv
// Branch resolution stage: registers the fetched instruction, decides taken
// branches from registered state and squashes the wrong-path slot.
module branch_control
    import branch_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       instr,
    input  logic             instr_valid,
    input  logic             alu_zero,
    input  logic             alu_zero_we,
    output logic [7:0]       pc_control,
    output logic [7:0]       jump_offset,
    output logic             flush,
    output logic [CNT_W-1:0] taken_count
);
    logic [7:0]       ir_q, ir_d;
    state_t           state_q, state_d;
    logic             z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       is_branch;
    logic       is_cond;
    logic [7:0] disp;
    logic       taken;

    branch_decoder u_dec (
        .ir        (ir_q),
        .is_branch (is_branch),
        .is_cond   (is_cond),
        .disp      (disp)
    );

    // Decision uses the flag value before any same-cycle write.
    always_comb begin
        taken       = (state_q == RUN) && is_branch && (!is_cond || z_q);
        flush       = (state_q == SQUASH);
        pc_control  = taken ? 8'hFF : 8'h00;
        // PC has already moved to branch_addr+1, and the adder adds one more.
        jump_offset = taken ? (disp - 8'd2) : 8'h00;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = taken ? SQUASH : RUN;
            SQUASH:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        ir_d  = (instr_valid && !flush) ? instr : NOP;
        z_d   = alu_zero_we ? alu_zero : z_q;
        cnt_d = cnt_q;
        if (taken && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q    <= NOP;
            state_q <= RUN;
            z_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ir_q    <= ir_d;
            state_q <= state_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
        end
    end

    assign taken_count = cnt_q;
endmodule

// File: tb/tb_branch_control.sv
// Bench for branch_control: vector table, directed PC sequences and a
// randomized program run against an arithmetic reference model.
module tb_branch_control;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [7:0]       instr;
    logic             instr_valid;
    logic             alu_zero;
    logic             alu_zero_we;
    logic [7:0]       pc_control;
    logic [7:0]       jump_offset;
    logic             flush;
    logic [CNT_W-1:0] taken_count;

    branch_control #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .alu_zero    (alu_zero),
        .alu_zero_we (alu_zero_we),
        .pc_control  (pc_control),
        .jump_offset (jump_offset),
        .flush       (flush),
        .taken_count (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    function automatic void chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Program memory and external program counter driven by DUT outputs.
    logic [7:0] mem [256];
    logic [7:0] pc;
    logic       drv_valid, drv_we, drv_az;

    // Reference model: what IR holds, whether this slot is squashed, flag, count.
    int m_ir, m_z, m_cnt;
    bit m_sq;

    function automatic void model_out(output int e_pcc, output int e_off,
                                      output int e_fl, output bit tk);
        int op, d;
        op = m_ir / 64;
        d  = m_ir % 64;
        if (d >= 32) d = d - 64;
        tk    = !m_sq && (op == 2 || (op == 3 && m_z != 0));
        e_pcc = tk ? 255 : 0;
        e_off = tk ? ((d - 2 + 256) % 256) : 0;
        e_fl  = m_sq ? 1 : 0;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        instr = 8'h00; instr_valid = 1'b1; alu_zero = 1'b0; alu_zero_we = 1'b0;
        repeat (2) @(negedge clk);
        pc = 8'h00; m_ir = 0; m_z = 0; m_cnt = 0; m_sq = 1'b0;
        drv_valid = 1'b1; drv_we = 1'b0; drv_az = 1'b0;
        rst_n = 1'b1;
    endtask

    // One clock: check outputs against the model, fetch mem[pc], advance.
    task automatic cycle();
        int e_pcc, e_off, e_fl;
        bit tk;
        logic [7:0] cap_pcc, cap_off, fetched;
        model_out(e_pcc, e_off, e_fl, tk);
        chk("model pc_control", int'(pc_control), e_pcc);
        chk("model jump_offset", int'(jump_offset), e_off);
        chk("model flush", int'(flush), e_fl);
        chk("model taken_count", int'(taken_count), m_cnt);
        fetched     = mem[pc];
        instr       = fetched;
        instr_valid = drv_valid;
        alu_zero_we = drv_we;
        alu_zero    = drv_az;
        cap_pcc     = pc_control;
        cap_off     = jump_offset;
        @(posedge clk);
        m_ir = (drv_valid && !m_sq) ? int'(fetched) : 0;
        if (drv_we) m_z = drv_az ? 1 : 0;
        if (tk && m_cnt < CNT_MAX) m_cnt++;
        m_sq = tk;
        pc = pc + 8'd1 + ((cap_pcc == 8'hFF) ? cap_off : 8'h00);
        @(negedge clk);
    endtask

    task automatic run_to(input logic [7:0] addr);
        int budget;
        budget = 0;
        while (pc != addr && budget < 300) begin
            cycle();
            budget++;
        end
        if (pc != addr) chk("run_to reached pc", int'(pc), int'(addr));
    endtask

    typedef struct {
        logic [7:0] in_instr;
        logic       in_valid;
        logic       in_we;
        logic       in_az;
        logic [7:0] ex_pcc;
        logic [7:0] ex_off;
        logic       ex_fl;
        int         ex_cnt;
    } vec_t;

    vec_t vecs [14];

    initial begin
        rst_n = 1'b0;
        instr = 8'h00; instr_valid = 1'b0; alu_zero = 1'b0; alu_zero_we = 1'b0;
        pc = 8'h00; drv_valid = 1'b1; drv_we = 1'b0; drv_az = 1'b0;
        m_ir = 0; m_z = 0; m_cnt = 0; m_sq = 1'b0;

        // Each row: inputs for one cycle, outputs expected in the next cycle.
        vecs[0]  = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 0};
        vecs[1]  = '{8'h85, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h03, 1'b0, 0};
        vecs[2]  = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1};
        vecs[3]  = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1};
        vecs[4]  = '{8'hC2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1};
        vecs[5]  = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1};
        vecs[6]  = '{8'hC2, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1};
        vecs[7]  = '{8'h8A, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 2};
        vecs[8]  = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2};
        vecs[9]  = '{8'h3F, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2};
        vecs[10] = '{8'h7F, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2};
        vecs[11] = '{8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2};
        vecs[12] = '{8'hA0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hDE, 1'b0, 2};
        vecs[13] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3};

        // Reset state, checked while reset is held.
        @(negedge clk);
        chk("reset pc_control", int'(pc_control), 0);
        chk("reset jump_offset", int'(jump_offset), 0);
        chk("reset flush", int'(flush), 0);
        chk("reset taken_count", int'(taken_count), 0);

        // Vector table
        do_reset();
        for (int i = 0; i < 14; i++) begin
            instr = vecs[i].in_instr; instr_valid = vecs[i].in_valid;
            alu_zero_we = vecs[i].in_we; alu_zero = vecs[i].in_az;
            @(negedge clk);
            $display("vec %0d instr=%02h -> pc_control=%02h jump_offset=%02h flush=%0d taken_count=%0d",
                     i, vecs[i].in_instr, pc_control, jump_offset, flush, taken_count);
            chk("vec pc_control", int'(pc_control), int'(vecs[i].ex_pcc));
            chk("vec jump_offset", int'(jump_offset), int'(vecs[i].ex_off));
            chk("vec flush", int'(flush), int'(vecs[i].ex_fl));
            chk("vec taken_count", int'(taken_count), vecs[i].ex_cnt);
        end

        // NOP stream then JMP +5 at pc=10
        clear_mem(); mem[10] = 8'h85;
        do_reset();
        for (int i = 0; i < 3; i++) cycle();
        chk("nop stream pc", int'(pc), 3);
        run_to(8'd10);
        cycle();
        chk("jmp decode pc_control", int'(pc_control), 8'hFF);
        chk("jmp decode jump_offset", int'(jump_offset), 8'h03);
        cycle();
        chk("jmp target pc", int'(pc), 15);
        chk("jmp flush", int'(flush), 1);
        cycle();
        chk("jmp flush one cycle", int'(flush), 0);
        chk("jmp taken_count", int'(taken_count), 1);
        $display("seq jmp+5 done pc=%0d", pc);

        // JZ -4 at pc=20, Z=0 then Z=1
        clear_mem(); mem[20] = 8'hFC;
        do_reset();
        run_to(8'd20); cycle(); cycle();
        chk("jz z0 pc", int'(pc), 22);
        chk("jz z0 flush", int'(flush), 0);
        do_reset();
        drv_we = 1'b1; drv_az = 1'b1; cycle(); drv_we = 1'b0; drv_az = 1'b0;
        run_to(8'd20); cycle(); cycle();
        chk("jz z1 pc", int'(pc), 16);
        chk("jz z1 flush", int'(flush), 1);
        $display("seq jz done pc=%0d", pc);

        // Flag write in the decode cycle is not seen; next JZ is taken
        clear_mem(); mem[20] = 8'hC4; mem[22] = 8'hC4;
        do_reset();
        run_to(8'd20); cycle();
        drv_we = 1'b1; drv_az = 1'b1; cycle(); drv_we = 1'b0; drv_az = 1'b0;
        chk("jz old z pc", int'(pc), 22);
        cycle(); cycle();
        chk("jz new z pc", int'(pc), 26);
        $display("seq jz same-cycle write done pc=%0d", pc);

        // Wrap-around and back-to-back jumps
        clear_mem(); mem[254] = 8'h81;
        do_reset();
        run_to(8'd254); cycle(); cycle();
        chk("jmp+1 at 254 pc", int'(pc), 255);
        clear_mem(); mem[254] = 8'h83;
        do_reset();
        run_to(8'd254); cycle(); cycle();
        chk("jmp+3 wrap pc", int'(pc), 1);
        clear_mem(); mem[30] = 8'h85; mem[31] = 8'h85;
        do_reset();
        run_to(8'd30); cycle(); cycle();
        chk("b2b first target pc", int'(pc), 35);
        cycle();
        chk("b2b second not taken pc", int'(pc), 36);
        chk("b2b taken_count", int'(taken_count), 1);
        $display("seq wrap/back-to-back done pc=%0d", pc);

        // Reset during SQUASH
        clear_mem(); mem[10] = 8'h85;
        do_reset();
        run_to(8'd10); cycle(); cycle();
        chk("pre-reset flush", int'(flush), 1);
        rst_n = 1'b0;
        #1;
        chk("async reset pc_control", int'(pc_control), 0);
        chk("async reset jump_offset", int'(jump_offset), 0);
        chk("async reset flush", int'(flush), 0);
        chk("async reset taken_count", int'(taken_count), 0);
        @(negedge clk);
        do_reset();
        cycle();
        chk("post-reset flush", int'(flush), 0);
        run_to(8'd10); cycle(); cycle(); cycle();
        chk("post-reset taken_count", int'(taken_count), 1);
        $display("seq reset-in-squash done pc=%0d", pc);

        // Saturation
        for (int i = 0; i < 256; i++) mem[i] = 8'h81;
        do_reset();
        for (int i = 0; i < 40; i++) cycle();
        chk("saturated taken_count", int'(taken_count), CNT_MAX);

        // Randomized program against the model
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(9) < 4) mem[i] = 8'($urandom_range(128, 255));
            else mem[i] = 8'($urandom_range(0, 127));
        end
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drv_valid = ($urandom_range(9) != 0);
            drv_we    = ($urandom_range(4) == 0);
            drv_az    = $urandom_range(1) != 0;
            cycle();
        end
        $display("random run done pc=%0d taken_count=%0d", pc, taken_count);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
